eth_idma_desc_sched: RTL and testbench

// Multi-channel descriptor scheduler in front of the iDMA backend of the Ethernet subsystem.

---
 rtl/eth_idma_desc_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_eth_idma_desc_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_idma_desc_sched.sv
// Multi-channel iDMA descriptor scheduler: per-channel queues, round-robin issue, in-order tag tracking.
// Optional feature macro ETH_IDMA_SCHED_PRIO_EN: channel 0 gets strict priority over the others.
module eth_idma_desc_sched #(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned QueueDepth     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned TFLenWidth     = 32,
  localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int unsigned LvlW  = $clog2(QueueDepth + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_valid_i,
  output logic                        push_ready_o,
  input  logic [ChanW-1:0]            push_chan_i,
  input  logic [AddrWidth-1:0]        push_src_addr_i,
  input  logic [AddrWidth-1:0]        push_dst_addr_i,
  input  logic [TFLenWidth-1:0]       push_len_i,
  input  logic [2:0]                  push_src_proto_i,
  input  logic [2:0]                  push_dst_proto_i,
  input  logic [NumChannels-1:0]      chan_en_i,
  input  logic [NumChannels-1:0]      chan_flush_i,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic [AddrWidth-1:0]        req_src_addr_o,
  output logic [AddrWidth-1:0]        req_dst_addr_o,
  output logic [TFLenWidth-1:0]       req_len_o,
  output logic [2:0]                  req_src_proto_o,
  output logic [2:0]                  req_dst_proto_o,
  input  logic                        rsp_valid_i,
  output logic                        rsp_ready_o,
  input  logic                        rsp_error_i,
  output logic [NumChannels-1:0]      irq_o,
  output logic [NumChannels-1:0]      err_o,
  input  logic [NumChannels-1:0]      irq_clr_i,
  output logic [NumChannels*LvlW-1:0] chan_level_o,
  output logic                        busy_o
);

  localparam int unsigned QPtrW   = $clog2(QueueDepth);
  localparam int unsigned TagPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned TagCntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned OccW    = TagCntW + 1;

  typedef struct packed {
    logic [AddrWidth-1:0]  srcAddr;
    logic [AddrWidth-1:0]  dstAddr;
    logic [TFLenWidth-1:0] len;
    logic [2:0]            srcProto;
    logic [2:0]            dstProto;
  } desc_t;

  function automatic logic [ChanW-1:0] nextChan(input logic [ChanW-1:0] c);
    return (c == ChanW'(NumChannels - 1)) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [TagPtrW-1:0] nextTag(input logic [TagPtrW-1:0] p);
    return (p == TagPtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  desc_t            qMem_q [NumChannels][QueueDepth];
  logic [QPtrW-1:0] qWr_q  [NumChannels];
  logic [QPtrW-1:0] qWr_d  [NumChannels];
  logic [QPtrW-1:0] qRd_q  [NumChannels];
  logic [QPtrW-1:0] qRd_d  [NumChannels];
  logic [LvlW-1:0]  qCnt_q [NumChannels];
  logic [LvlW-1:0]  qCnt_d [NumChannels];

  logic [NumChannels-1:0] enq, deq, lenZero, arbReq, rrReq, qFull, qNonEmpty, rspSet;
  desc_t                  pushDesc, headDesc;
  logic                   pushReady, pushHs, anyReq, load, reqHs, rspHs;
  logic [ChanW-1:0]       winner, rrPtr_q, rrPtr_d;
  logic [OccW-1:0]        occ;

  logic                   issValid_q, issValid_d;
  desc_t                  issDesc_q, issDesc_d;
  logic [ChanW-1:0]       issChan_q, issChan_d;

  logic [ChanW-1:0]       tagMem_q [MaxOutstanding];
  logic [TagPtrW-1:0]     tagWr_q, tagWr_d, tagRd_q, tagRd_d;
  logic [TagCntW-1:0]     tagCnt_q, tagCnt_d;
  logic [ChanW-1:0]       tagHead;

  logic [NumChannels-1:0] irq_q, irq_d, err_q, err_d;

  // Out-of-range channels never match, so they see ready=1 and are dropped.
  always_comb begin
    pushDesc = '{srcAddr: push_src_addr_i, dstAddr: push_dst_addr_i, len: push_len_i,
                 srcProto: push_src_proto_i, dstProto: push_dst_proto_i};
    pushReady = 1'b1;
    qFull     = '0;
    qNonEmpty = '0;
    enq       = '0;
    lenZero   = '0;
    for (int c = 0; c < NumChannels; c++) begin
      qFull[c]     = (qCnt_q[c] == LvlW'(QueueDepth));
      qNonEmpty[c] = (qCnt_q[c] != '0);
      if ((push_chan_i == ChanW'(c)) && qFull[c]) pushReady = 1'b0;
    end
    pushHs = push_valid_i && pushReady;
    for (int c = 0; c < NumChannels; c++) begin
      if (pushHs && (push_chan_i == ChanW'(c)) && !chan_flush_i[c]) begin
        enq[c]     = (push_len_i != '0);
        lenZero[c] = (push_len_i == '0);
      end
    end
  end

  // Two-pass round-robin: first from the pointer upwards, then wrap around.
  always_comb begin
    arbReq   = chan_en_i & qNonEmpty & ~chan_flush_i;
    rrReq    = arbReq;
    winner   = '0;
    anyReq   = 1'b0;
    headDesc = '0;
`ifdef ETH_IDMA_SCHED_PRIO_EN
    rrReq[0] = 1'b0;
    if (arbReq[0]) anyReq = 1'b1;
`endif
    for (int c = 0; c < NumChannels; c++) begin
      if (!anyReq && rrReq[c] && (ChanW'(c) >= rrPtr_q)) begin
        winner = ChanW'(c);
        anyReq = 1'b1;
      end
    end
    for (int c = 0; c < NumChannels; c++) begin
      if (!anyReq && rrReq[c]) begin
        winner = ChanW'(c);
        anyReq = 1'b1;
      end
    end
    for (int c = 0; c < NumChannels; c++) begin
      if (winner == ChanW'(c)) headDesc = qMem_q[c][qRd_q[c]];
    end
  end

  // The issue register counts as in flight, so loads stop once MaxOutstanding is reached.
  always_comb begin
    reqHs      = issValid_q && req_ready_i;
    occ        = OccW'(tagCnt_q) + OccW'(issValid_q);
    load       = anyReq && (!issValid_q || req_ready_i) && (occ < OccW'(MaxOutstanding));
    issValid_d = issValid_q;
    issDesc_d  = issDesc_q;
    issChan_d  = issChan_q;
    rrPtr_d    = rrPtr_q;
    deq        = '0;
    if (load) begin
      issValid_d = 1'b1;
      issDesc_d  = headDesc;
      issChan_d  = winner;
      for (int c = 0; c < NumChannels; c++) deq[c] = (winner == ChanW'(c));
`ifdef ETH_IDMA_SCHED_PRIO_EN
      if (winner != '0) rrPtr_d = nextChan(winner);
`else
      rrPtr_d = nextChan(winner);
`endif
    end else if (reqHs) begin
      issValid_d = 1'b0;
    end
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      qWr_d[c]  = qWr_q[c];
      qRd_d[c]  = qRd_q[c];
      qCnt_d[c] = qCnt_q[c];
      if (chan_flush_i[c]) begin
        qWr_d[c]  = '0;
        qRd_d[c]  = '0;
        qCnt_d[c] = '0;
      end else begin
        if (enq[c]) qWr_d[c] = qWr_q[c] + 1'b1;
        if (deq[c]) qRd_d[c] = qRd_q[c] + 1'b1;
        qCnt_d[c] = qCnt_q[c] + LvlW'(enq[c]) - LvlW'(deq[c]);
      end
    end
  end

  // Tags retire in issue order; a response with nothing in flight is ignored.
  always_comb begin
    tagHead  = tagMem_q[tagRd_q];
    rspHs    = rsp_valid_i && (tagCnt_q != '0);
    tagWr_d  = reqHs ? nextTag(tagWr_q) : tagWr_q;
    tagRd_d  = rspHs ? nextTag(tagRd_q) : tagRd_q;
    tagCnt_d = tagCnt_q + TagCntW'(reqHs) - TagCntW'(rspHs);
    rspSet   = '0;
    for (int c = 0; c < NumChannels; c++) rspSet[c] = rspHs && (tagHead == ChanW'(c));
    irq_d = lenZero | rspSet | (irq_q & ~irq_clr_i);
    err_d = lenZero | (rspSet & {NumChannels{rsp_error_i}}) | (err_q & ~irq_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        qWr_q[c]  <= '0;
        qRd_q[c]  <= '0;
        qCnt_q[c] <= '0;
        for (int e = 0; e < QueueDepth; e++) qMem_q[c][e] <= '0;
      end
      for (int t = 0; t < MaxOutstanding; t++) tagMem_q[t] <= '0;
      rrPtr_q    <= '0;
      issValid_q <= 1'b0;
      issDesc_q  <= '0;
      issChan_q  <= '0;
      tagWr_q    <= '0;
      tagRd_q    <= '0;
      tagCnt_q   <= '0;
      irq_q      <= '0;
      err_q      <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (enq[c]) qMem_q[c][qWr_q[c]] <= pushDesc;
        qWr_q[c]  <= qWr_d[c];
        qRd_q[c]  <= qRd_d[c];
        qCnt_q[c] <= qCnt_d[c];
      end
      if (reqHs) tagMem_q[tagWr_q] <= issChan_q;
      rrPtr_q    <= rrPtr_d;
      issValid_q <= issValid_d;
      issDesc_q  <= issDesc_d;
      issChan_q  <= issChan_d;
      tagWr_q    <= tagWr_d;
      tagRd_q    <= tagRd_d;
      tagCnt_q   <= tagCnt_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    chan_level_o = '0;
    for (int c = 0; c < NumChannels; c++) chan_level_o[c*LvlW +: LvlW] = qCnt_q[c];
  end

  assign push_ready_o    = pushReady;
  assign req_valid_o     = issValid_q;
  assign req_src_addr_o  = issDesc_q.srcAddr;
  assign req_dst_addr_o  = issDesc_q.dstAddr;
  assign req_len_o       = issDesc_q.len;
  assign req_src_proto_o = issDesc_q.srcProto;
  assign req_dst_proto_o = issDesc_q.dstProto;
  assign rsp_ready_o     = (tagCnt_q != '0);
  assign irq_o           = irq_q;
  assign err_o           = err_q;
  assign busy_o          = (|qNonEmpty) || issValid_q || (tagCnt_q != '0);

endmodule

// File: tb/tb_eth_idma_desc_sched.sv
// Self-checking bench for eth_idma_desc_sched: directed scenarios with randomized payloads
// checked against a queue-based round-robin reference model.
module tb_eth_idma_desc_sched;

  localparam int NCh = 2;
  localparam int LvW = 3;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [2:0]  sp;
    logic [2:0]  dp;
  } desc_s;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             push_valid_i, push_ready_o;
  logic [0:0]       push_chan_i;
  logic [31:0]      push_src_addr_i, push_dst_addr_i, push_len_i;
  logic [2:0]       push_src_proto_i, push_dst_proto_i;
  logic [NCh-1:0]   chan_en_i, chan_flush_i;
  logic             req_valid_o, req_ready_i;
  logic [31:0]      req_src_addr_o, req_dst_addr_o, req_len_o;
  logic [2:0]       req_src_proto_o, req_dst_proto_o;
  logic             rsp_valid_i, rsp_ready_o, rsp_error_i;
  logic [NCh-1:0]   irq_o, err_o, irq_clr_i;
  logic [NCh*LvW-1:0] chan_level_o;
  logic             busy_o;

  int testsRun = 0;
  int testsFailed = 0;
  desc_s issuedQ[$];

  eth_idma_desc_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_chan_i(push_chan_i),
    .push_src_addr_i(push_src_addr_i), .push_dst_addr_i(push_dst_addr_i), .push_len_i(push_len_i),
    .push_src_proto_i(push_src_proto_i), .push_dst_proto_i(push_dst_proto_i),
    .chan_en_i(chan_en_i), .chan_flush_i(chan_flush_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_src_addr_o(req_src_addr_o), .req_dst_addr_o(req_dst_addr_o), .req_len_o(req_len_o),
    .req_src_proto_o(req_src_proto_o), .req_dst_proto_o(req_dst_proto_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
    .irq_o(irq_o), .err_o(err_o), .irq_clr_i(irq_clr_i),
    .chan_level_o(chan_level_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Records every backend request handshake in issue order.
  always @(negedge clk_i)
    if (rst_ni && req_valid_o && req_ready_i)
      issuedQ.push_back({req_src_addr_o, req_dst_addr_o, req_len_o, req_src_proto_o, req_dst_proto_o});

  function automatic desc_s randDesc();
    desc_s d;
    d.src = $urandom;
    d.dst = $urandom;
    d.len = 32'($urandom_range(1, 4096));
    d.sp  = 3'($urandom_range(0, 7));
    d.dp  = 3'($urandom_range(0, 7));
    return d;
  endfunction

  function automatic int level(input int c);
    return int'(chan_level_o[c*LvW +: LvW]);
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    push_valid_i = 0; push_chan_i = '0; push_src_addr_i = '0; push_dst_addr_i = '0;
    push_len_i = '0; push_src_proto_i = '0; push_dst_proto_i = '0;
    chan_en_i = '1; chan_flush_i = '0; req_ready_i = 0; rsp_valid_i = 0; rsp_error_i = 0;
    irq_clr_i = '0;
    rst_ni = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1;
    issuedQ.delete();
  endtask

  task automatic doPush(input int ch, input desc_s d, output bit acc);
    push_valid_i = 1; push_chan_i = 1'(ch);
    push_src_addr_i = d.src; push_dst_addr_i = d.dst; push_len_i = d.len;
    push_src_proto_i = d.sp; push_dst_proto_i = d.dp;
    #1;
    acc = push_ready_o;
    cycle();
    push_valid_i = 0;
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if (req_valid_o !== 1'b0 || req_src_addr_o !== '0 || req_len_o !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_req: valid=%b src=%h len=%h expected all 0", req_valid_o, req_src_addr_o, req_len_o);
    end
    testsRun++;
    if ({irq_o, err_o, chan_level_o, busy_o, rsp_ready_o} !== '0) begin
      testsFailed++; $display("[TB] FAIL reset_status: irq=%b err=%b lvl=%h busy=%b rspr=%b expected 0", irq_o, err_o, chan_level_o, busy_o, rsp_ready_o);
    end
    rsp_valid_i = 1; rsp_error_i = 1;
    cycle(); cycle();
    rsp_valid_i = 0; rsp_error_i = 0;
    testsRun++;
    if ({irq_o, err_o, busy_o} !== '0) begin
      testsFailed++; $display("[TB] FAIL stray_rsp: irq=%b err=%b busy=%b expected 0", irq_o, err_o, busy_o);
    end
  endtask

  task automatic test_single();
    desc_s d;
    bit acc;
    doReset();
    d = randDesc(); d.src = 32'h1000; d.dst = 32'h0; d.len = 32'd64;
    req_ready_i = 1;
    doPush(0, d, acc);
    testsRun++;
    if (acc !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_push: ready=%b expected 1", acc); end
    testsRun++;
    if (req_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL latency_c1: req_valid=%b expected 0", req_valid_o); end
    cycle();
    testsRun++;
    if (req_valid_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL latency_c2: req_valid=%b expected 1", req_valid_o); end
    testsRun++;
    if ({req_src_addr_o, req_dst_addr_o, req_len_o, req_src_proto_o, req_dst_proto_o} !== d) begin
      testsFailed++; $display("[TB] FAIL single_payload: src=%h dst=%h len=%h expected src=%h dst=%h len=%h", req_src_addr_o, req_dst_addr_o, req_len_o, d.src, d.dst, d.len);
    end
    cycle();
    testsRun++;
    if (req_valid_o !== 1'b0 || rsp_ready_o !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL single_inflight: req_valid=%b rsp_ready=%b expected 0/1", req_valid_o, rsp_ready_o);
    end
    rsp_valid_i = 1;
    cycle();
    rsp_valid_i = 0;
    testsRun++;
    if (irq_o !== 2'b01 || err_o !== 2'b00 || busy_o !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL single_irq: irq=%b err=%b busy=%b expected 01/00/0", irq_o, err_o, busy_o);
    end
  endtask

  task automatic test_round_robin();
    int    pendCh[$];
    desc_s pendD[$];
    desc_s d, exp;
    bit    acc;
    int    n, ptr;
    doReset();
    chan_en_i = '0;
    for (int k = 0; k < 6; k++) begin
      d = randDesc();
      doPush(k / 3, d, acc);
      pendCh.push_back(k / 3); pendD.push_back(d);
    end
    testsRun++;
    if (level(0) != 3 || level(1) != 3) begin
      testsFailed++; $display("[TB] FAIL rr_levels: lvl0=%0d lvl1=%0d expected 3/3", level(0), level(1));
    end
    chan_en_i = 2'b11; rsp_valid_i = 1;
    n = 0;
    while (issuedQ.size() < 6 && n < 200) begin
      req_ready_i = 1'($urandom_range(0, 1));
      cycle(); n++;
    end
    req_ready_i = 0;
    repeat (3) cycle();
    rsp_valid_i = 0;
    testsRun++;
    if (issuedQ.size() != 6) begin
      testsFailed++; $display("[TB] FAIL rr_count: issued=%0d expected 6", issuedQ.size());
    end
    ptr = 0;
    for (int k = 0; k < 6 && k < issuedQ.size(); k++) begin
      bit found = 0;
      for (int i = 0; i < NCh && !found; i++) begin
        int c = (ptr + i) % NCh;
        for (int j = 0; j < pendCh.size() && !found; j++) begin
          if (pendCh[j] == c) begin
            exp = pendD[j]; pendCh.delete(j); pendD.delete(j);
            ptr = (c + 1) % NCh; found = 1;
          end
        end
      end
      testsRun++;
      if (issuedQ[k] !== exp) begin
        testsFailed++; $display("[TB] FAIL rr_order[%0d]: got %h expected %h", k, issuedQ[k], exp);
      end
    end
    testsRun++;
    if (irq_o !== 2'b11 || busy_o !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rr_done: irq=%b busy=%b expected 11/0", irq_o, busy_o);
    end
  endtask

  task automatic test_outstanding();
    desc_s pushed[6];
    bit    acc;
    int    accCnt, n, hits;
    doReset();
    req_ready_i = 1;
    accCnt = 0;
    for (int k = 0; k < 6; k++) begin
      pushed[k] = randDesc();
      doPush(k % 2, pushed[k], acc);
      accCnt += int'(acc);
    end
    repeat (20) cycle();
    testsRun++;
    if (accCnt != 6) begin testsFailed++; $display("[TB] FAIL os_accept: accepted=%0d expected 6", accCnt); end
    testsRun++;
    if (issuedQ.size() != 4) begin testsFailed++; $display("[TB] FAIL os_limit: issued=%0d expected 4", issuedQ.size()); end
    testsRun++;
    if (level(0) + level(1) != 2 || req_valid_o !== 1'b0 || rsp_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL os_state: lvl=%0d req_valid=%b rsp_ready=%b busy=%b expected 2/0/1/1", level(0) + level(1), req_valid_o, rsp_ready_o, busy_o);
    end
    rsp_valid_i = 1;
    n = 0;
    while ((issuedQ.size() < 6 || busy_o) && n < 100) begin cycle(); n++; end
    rsp_valid_i = 0;
    testsRun++;
    if (issuedQ.size() != 6 || busy_o !== 1'b0 || irq_o !== 2'b11 || err_o !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL os_drain: issued=%0d busy=%b irq=%b err=%b expected 6/0/11/00", issuedQ.size(), busy_o, irq_o, err_o);
    end
    hits = 0;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < issuedQ.size(); j++)
        if (issuedQ[j] === pushed[k]) hits++;
    testsRun++;
    if (hits != 6) begin testsFailed++; $display("[TB] FAIL os_content: matches=%0d expected 6", hits); end
  endtask

  task automatic test_zero_len();
    desc_s d;
    bit    acc;
    doReset();
    req_ready_i = 1;
    d = randDesc(); d.len = '0;
    doPush(1, d, acc);
    testsRun++;
    if (acc !== 1'b1 || irq_o !== 2'b10 || err_o !== 2'b10 || level(1) != 0) begin
      testsFailed++; $display("[TB] FAIL zlen_flags: acc=%b irq=%b err=%b lvl1=%0d expected 1/10/10/0", acc, irq_o, err_o, level(1));
    end
    repeat (4) cycle();
    testsRun++;
    if (issuedQ.size() != 0) begin testsFailed++; $display("[TB] FAIL zlen_noreq: issued=%0d expected 0", issuedQ.size()); end
    irq_clr_i = 2'b10;
    cycle();
    irq_clr_i = '0;
    testsRun++;
    if (irq_o !== 2'b00 || err_o !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL zlen_clear: irq=%b err=%b expected 00/00", irq_o, err_o);
    end
  endtask

  task automatic test_flush();
    desc_s d0, d1, d;
    bit    acc;
    int    n;
    doReset();
    chan_en_i = 2'b01;
    for (int k = 0; k < 4; k++) doPush(1, randDesc(), acc);
    testsRun++;
    if (level(1) != 4) begin testsFailed++; $display("[TB] FAIL flush_fill: lvl1=%0d expected 4", level(1)); end
    push_chan_i = 1'b0; #1;
    testsRun++;
    if (push_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_other: ready=%b expected 1", push_ready_o); end
    doPush(1, randDesc(), acc);
    testsRun++;
    if (acc !== 1'b0 || level(1) != 4) begin
      testsFailed++; $display("[TB] FAIL full_reject: ready=%b lvl1=%0d expected 0/4", acc, level(1));
    end
    req_ready_i = 1; rsp_valid_i = 1;
    d0 = randDesc(); d1 = randDesc();
    doPush(0, d0, acc);
    doPush(0, d1, acc);
    chan_flush_i = 2'b10;
    cycle();
    chan_flush_i = '0;
    testsRun++;
    if (level(1) != 0) begin testsFailed++; $display("[TB] FAIL flush_level: lvl1=%0d expected 0", level(1)); end
    n = 0;
    while ((issuedQ.size() < 2 || busy_o) && n < 50) begin cycle(); n++; end
    testsRun++;
    if (issuedQ.size() != 2 || irq_o !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL flush_ch0: issued=%0d irq=%b expected 2/01", issuedQ.size(), irq_o);
    end else begin
      testsRun++;
      if (issuedQ[0] !== d0 || issuedQ[1] !== d1) begin
        testsFailed++; $display("[TB] FAIL flush_ch0_data: got %h,%h expected %h,%h", issuedQ[0], issuedQ[1], d0, d1);
      end
    end
    chan_en_i = 2'b11;
    d = randDesc();
    chan_flush_i = 2'b10;
    doPush(1, d, acc);
    chan_flush_i = '0;
    repeat (4) cycle();
    testsRun++;
    if (acc !== 1'b1 || level(1) != 0 || issuedQ.size() != 2) begin
      testsFailed++; $display("[TB] FAIL push_flush: acc=%b lvl1=%0d issued=%0d expected 1/0/2", acc, level(1), issuedQ.size());
    end
    rsp_valid_i = 0;
  endtask

  task automatic test_err_clear();
    bit acc;
    int n;
    doReset();
    req_ready_i = 1;
    doPush(0, randDesc(), acc);
    n = 0;
    while (rsp_ready_o !== 1'b1 && n < 20) begin cycle(); n++; end
    testsRun++;
    if (rsp_ready_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_wait: rsp_ready=%b expected 1", rsp_ready_o); end
    rsp_valid_i = 1; rsp_error_i = 1; irq_clr_i = 2'b01;
    cycle();
    rsp_valid_i = 0; rsp_error_i = 0; irq_clr_i = '0;
    testsRun++;
    if (irq_o !== 2'b01 || err_o !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL set_wins: irq=%b err=%b expected 01/01", irq_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_outstanding();
    test_zero_len();
    test_flush();
    test_err_clear();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
